bit_ser_operand_tx: RTL and testbench

- Parallel-to-serial operand transmitter that drives the bit-serial adder's A/B inputs and its clear/start controls.
- Accepts two WIDTH-bit operands over a valid/ready handshake.
- Sequence per transfer: pulse the adder clear, shift both operands out LSB-first, append one zero flush bit so the carry reaches the (WIDTH+1)-bit result, then assert start and signal done.

---
 rtl/bit_ser_operand_tx.sv | 198 +++++++++++++++++++
 tb/tb_bit_ser_operand_tx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bit_ser_operand_tx.sv
// ---------------------------------------------------------------------------
// bit_ser_operand_tx
// Parallel-to-serial operand transmitter for a bit-serial adder. It accepts
// two WIDTH-bit operands over a valid/ready handshake. It pulses the adder
// clear and shifts both operands out LSB-first. It then appends one zero
// flush bit so that the carry reaches the (WIDTH+1)-bit result. Finally it
// asserts the adder start/hold and pulses done.
//
// Ports:
//   clk          in   system clock, rising edge
//   clr          in   synchronous active-high reset
//   load_valid   in   operands present on op_a/op_b
//   load_ready   out  high only in IDLE (decoded from the state register)
//   op_a, op_b   in   WIDTH-bit operands, captured on acceptance
//   ser_a, ser_b out  serial operand bits, LSB first
//   bit_valid    out  high for every data bit and the flush bit
//   first_bit    out  high with bit 0 only
//   last_bit     out  high with the flush bit only
//   adder_clr_n  out  active-low adder clear, low for CLR_CYCLES cycles
//   adder_set_n  out  active-low adder start/hold, low from DONE until the
//                     next acceptance
//   busy         out  high in CLEAR, SHIFT, FLUSH
//   done         out  one-cycle pulse in DONE
//
// Optional feature (macro BIT_SER_OPERAND_TX_CAPTURE_EN):
//   ser_sum      in   serial sum bit from the adder, sampled every bit cycle
//   sum          out  (WIDTH+1)-bit captured sum, updated at the done edge
// ---------------------------------------------------------------------------
module bit_ser_operand_tx #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned CLR_CYCLES = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             ser_a,
    output logic             ser_b,
    output logic             bit_valid,
    output logic             first_bit,
    output logic             last_bit,
    output logic             adder_clr_n,
    output logic             adder_set_n,
    output logic             busy,
    output logic             done
`ifdef BIT_SER_OPERAND_TX_CAPTURE_EN
    ,
    input  logic             ser_sum,
    output logic [WIDTH:0]   sum
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned CLR_W = $clog2(CLR_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_FLUSH,
        S_DONE
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [CLR_W-1:0]   clr_cnt_q;
    logic [WIDTH-1:0]   sh_a_q;
    logic [WIDTH-1:0]   sh_b_q;
    logic               ser_a_q;
    logic               ser_b_q;
    logic               bit_valid_q;
    logic               first_bit_q;
    logic               last_bit_q;
    logic               adder_clr_n_q;
    logic               adder_set_n_q;
    logic               busy_q;
    logic               done_q;

    // Outputs are loaded on the edge that enters the cycle they describe,
    // so each state's outputs are valid for the whole of that state's cycle.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q       <= S_IDLE;
            bit_cnt_q     <= '0;
            clr_cnt_q     <= '0;
            sh_a_q        <= '0;
            sh_b_q        <= '0;
            ser_a_q       <= 1'b0;
            ser_b_q       <= 1'b0;
            bit_valid_q   <= 1'b0;
            first_bit_q   <= 1'b0;
            last_bit_q    <= 1'b0;
            adder_clr_n_q <= 1'b1;
            adder_set_n_q <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (load_valid) begin
                        state_q       <= S_CLEAR;
                        sh_a_q        <= op_a;
                        sh_b_q        <= op_b;
                        clr_cnt_q     <= '0;
                        adder_clr_n_q <= 1'b0;
                        adder_set_n_q <= 1'b1;
                        busy_q        <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (clr_cnt_q == CLR_W'(CLR_CYCLES - 1)) begin
                        // Present bit 0 as the clear ends.
                        state_q       <= S_SHIFT;
                        bit_cnt_q     <= '0;
                        ser_a_q       <= sh_a_q[0];
                        ser_b_q       <= sh_b_q[0];
                        sh_a_q        <= {1'b0, sh_a_q[WIDTH-1:1]};
                        sh_b_q        <= {1'b0, sh_b_q[WIDTH-1:1]};
                        bit_valid_q   <= 1'b1;
                        first_bit_q   <= 1'b1;
                        adder_clr_n_q <= 1'b1;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + CLR_W'(1);
                    end
                end
                S_SHIFT: begin
                    first_bit_q <= 1'b0;
                    if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
                        // Zero flush bit lets the final carry out.
                        state_q    <= S_FLUSH;
                        ser_a_q    <= 1'b0;
                        ser_b_q    <= 1'b0;
                        last_bit_q <= 1'b1;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        ser_a_q   <= sh_a_q[0];
                        ser_b_q   <= sh_b_q[0];
                        sh_a_q    <= {1'b0, sh_a_q[WIDTH-1:1]};
                        sh_b_q    <= {1'b0, sh_b_q[WIDTH-1:1]};
                    end
                end
                S_FLUSH: begin
                    state_q       <= S_DONE;
                    bit_valid_q   <= 1'b0;
                    last_bit_q    <= 1'b0;
                    busy_q        <= 1'b0;
                    done_q        <= 1'b1;
                    adder_set_n_q <= 1'b0;
                end
                S_DONE: begin
                    // adder_set_n stays low so the adder holds its result.
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign load_ready  = (state_q == S_IDLE);
    assign ser_a       = ser_a_q;
    assign ser_b       = ser_b_q;
    assign bit_valid   = bit_valid_q;
    assign first_bit   = first_bit_q;
    assign last_bit    = last_bit_q;
    assign adder_clr_n = adder_clr_n_q;
    assign adder_set_n = adder_set_n_q;
    assign busy        = busy_q;
    assign done        = done_q;

`ifdef BIT_SER_OPERAND_TX_CAPTURE_EN
    logic [WIDTH:0] cap_q;
    logic [WIDTH:0] sum_q;

    // Sum bits arrive LSB-first; shifting in at the MSB leaves the result
    // LSB-aligned after the flush bit.
    always_ff @(posedge clk) begin
        if (clr) begin
            cap_q <= '0;
            sum_q <= '0;
        end else begin
            if (bit_valid_q) begin
                cap_q <= {ser_sum, cap_q[WIDTH:1]};
            end
            if (state_q == S_DONE) begin
                sum_q <= cap_q;
            end
        end
    end

    assign sum = sum_q;
`endif

endmodule

// File: tb/tb_bit_ser_operand_tx.sv
// Testbench for bit_ser_operand_tx. It drives two instances: WIDTH=8 with
// CLR_CYCLES=1, and WIDTH=4 with CLR_CYCLES=3. Each output cycle is compared
// against a per-cycle trace computed from the transfer timeline.
module tb_bit_ser_operand_tx;

    logic       clk = 1'b0;
    logic       clr;
    logic       lv   [2];
    logic [7:0] opa  [2];
    logic [7:0] opb  [2];

    logic ready [2], sa [2], sb [2], bv [2], fb [2], lb [2];
    logic clrn  [2], setn [2], bsy [2], dn [2];
    logic [9:0] obs [2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

`ifdef BIT_SER_OPERAND_TX_CAPTURE_EN
    logic       ss    [2];
    logic       carry [2];
    logic [8:0] sum0;
    logic [4:0] sum1;
    logic [8:0] sumv  [2];

    // Behavioural bit-serial adder feeding ser_sum.
    always @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (!clrn[n])   carry[n] <= 1'b0;
            else if (bv[n]) carry[n] <= (sa[n] & sb[n]) | (sa[n] & carry[n]) | (sb[n] & carry[n]);
        end
    end
    assign ss[0]   = sa[0] ^ sb[0] ^ carry[0];
    assign ss[1]   = sa[1] ^ sb[1] ^ carry[1];
    assign sumv[0] = sum0;
    assign sumv[1] = 9'(sum1);
`endif

    bit_ser_operand_tx #(.WIDTH(8), .CLR_CYCLES(1)) dut0 (
        .clk(clk), .clr(clr), .load_valid(lv[0]), .load_ready(ready[0]),
        .op_a(opa[0]), .op_b(opb[0]), .ser_a(sa[0]), .ser_b(sb[0]),
        .bit_valid(bv[0]), .first_bit(fb[0]), .last_bit(lb[0]),
        .adder_clr_n(clrn[0]), .adder_set_n(setn[0]), .busy(bsy[0]), .done(dn[0])
`ifdef BIT_SER_OPERAND_TX_CAPTURE_EN
        , .ser_sum(ss[0]), .sum(sum0)
`endif
    );

    bit_ser_operand_tx #(.WIDTH(4), .CLR_CYCLES(3)) dut1 (
        .clk(clk), .clr(clr), .load_valid(lv[1]), .load_ready(ready[1]),
        .op_a(opa[1][3:0]), .op_b(opb[1][3:0]), .ser_a(sa[1]), .ser_b(sb[1]),
        .bit_valid(bv[1]), .first_bit(fb[1]), .last_bit(lb[1]),
        .adder_clr_n(clrn[1]), .adder_set_n(setn[1]), .busy(bsy[1]), .done(dn[1])
`ifdef BIT_SER_OPERAND_TX_CAPTURE_EN
        , .ser_sum(ss[1]), .sum(sum1)
`endif
    );

    // {load_ready, ser_a, ser_b, bit_valid, first_bit, last_bit,
    //  adder_clr_n, adder_set_n, busy, done}
    assign obs[0] = {ready[0], sa[0], sb[0], bv[0], fb[0], lb[0], clrn[0], setn[0], bsy[0], dn[0]};
    assign obs[1] = {ready[1], sa[1], sb[1], bv[1], fb[1], lb[1], clrn[1], setn[1], bsy[1], dn[1]};

    localparam logic [9:0] RST_VEC = 10'b1_00_000_11_00;

    // Expected outputs k cycles after the acceptance edge.
    function automatic logic [9:0] exp_vec(int c, int w, int k, logic [7:0] a, logic [7:0] b);
        int   i;
        logic e_rdy, e_sa, e_sb, e_bv, e_fb, e_lb, e_clrn, e_setn, e_busy, e_done;
        i      = k - c - 1;
        e_rdy  = (k > c + w + 2);
        e_sa   = (i >= 0 && i < w) ? a[i] : 1'b0;
        e_sb   = (i >= 0 && i < w) ? b[i] : 1'b0;
        e_bv   = (i >= 0 && i <= w);
        e_fb   = (i == 0);
        e_lb   = (i == w);
        e_clrn = !(k >= 1 && k <= c);
        e_setn = (k < c + w + 2);
        e_busy = (k <= c + w + 1);
        e_done = (k == c + w + 2);
        return {e_rdy, e_sa, e_sb, e_bv, e_fb, e_lb, e_clrn, e_setn, e_busy, e_done};
    endfunction

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic check_sum(input string tag, input logic [8:0] got, input logic [8:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s sum observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Issue one transfer on instance n, check every cycle through the return
    // to IDLE. With hold, load_valid stays high and the operand bus is
    // scrambled during the transfer; the next xfer call is then accepted at
    // the very next edge.
    task automatic xfer(input int n, input logic [7:0] a, input logic [7:0] b,
                        input bit hold, input string tag);
        int         c;
        int         w;
        logic [7:0] m;
        c = (n == 0) ? 1 : 3;
        w = (n == 0) ? 8 : 4;
        m = (n == 0) ? 8'hFF : 8'h0F;
        opa[n] = a;
        opb[n] = b;
        lv[n]  = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= c + w + 3; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            if (k == 1) begin
                if (hold) begin
                    opa[n] = 8'($urandom);
                    opb[n] = 8'($urandom);
                end else begin
                    lv[n] = 1'b0;
                end
            end
            check($sformatf("%s k=%0d", tag, k), obs[n], exp_vec(c, w, k, a, b));
        end
`ifdef BIT_SER_OPERAND_TX_CAPTURE_EN
        check_sum(tag, sumv[n], 9'(a & m) + 9'(b & m));
`else
        m = m;
`endif
    endtask

    // Start a transfer on instance 0 and reset it while bit 3 is on the wire.
    task automatic abort_xfer(input logic [7:0] a, input logic [7:0] b);
        opa[0] = a;
        opb[0] = b;
        lv[0]  = 1'b1;
        @(posedge clk); #1;
        lv[0] = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            check($sformatf("abort k=%0d", k), obs[0], exp_vec(1, 8, k, a, b));
        end
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("abort reset", obs[0], RST_VEC);
`ifdef BIT_SER_OPERAND_TX_CAPTURE_EN
        check_sum("abort reset", sumv[0], 9'd0);
`endif
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("abort quiet %0d", k), obs[0], RST_VEC);
        end
    endtask

    initial begin
        clr = 1'b1;
        for (int n = 0; n < 2; n++) begin
            lv[n]  = 1'b0;
            opa[n] = 8'd0;
            opb[n] = 8'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b0;
        check("reset inst0", obs[0], RST_VEC);
        check("reset inst1", obs[1], RST_VEC);
`ifdef BIT_SER_OPERAND_TX_CAPTURE_EN
        check_sum("reset sum0", sumv[0], 9'd0);
`endif

        // 7+3, then 6+4 back-to-back, then all-ones operands.
        xfer(0, 8'd7, 8'd3, 1'b0, "7+3");
        xfer(0, 8'd6, 8'd4, 1'b0, "6+4");
        xfer(0, 8'd255, 8'd255, 1'b0, "255+255");

        // load_valid held high: the second operands wait for IDLE.
        xfer(0, 8'($urandom), 8'($urandom), 1'b1, "hold");
        xfer(0, 8'($urandom), 8'($urandom), 1'b0, "after_hold");

        // Reset on bit 3, then a clean transfer.
        abort_xfer(8'hA5, 8'h5A);
        xfer(0, 8'($urandom), 8'($urandom), 1'b0, "post_abort");

        for (int r = 0; r < 6; r++) begin
            xfer(0, 8'($urandom), 8'($urandom), 1'b0, $sformatf("rand%0d", r));
        end

        // CLR_CYCLES=3, WIDTH=4 timing.
        xfer(1, 8'd9, 8'd7, 1'b0, "w4 9+7");
        xfer(1, 8'd15, 8'd15, 1'b0, "w4 15+15");
        for (int r = 0; r < 4; r++) begin
            xfer(1, 8'($urandom_range(15)), 8'($urandom_range(15)), 1'b0,
                 $sformatf("w4 rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
